// File: rtl/tow_pkg.sv
// Shared types and LED patterns for the tug-of-war reaction game.
package tow_pkg;

    localparam logic [6:0] DARK     = 7'b0000000;
    localparam logic [6:0] ALL_ON   = 7'b1111111;
    localparam logic [6:0] IDLE_PAT = 7'b1001101;

    localparam logic [6:0] L3 = 7'b1000000;
    localparam logic [6:0] L2 = 7'b0100000;
    localparam logic [6:0] L1 = 7'b0010000;
    localparam logic [6:0] C  = 7'b0001000;
    localparam logic [6:0] R1 = 7'b0000100;
    localparam logic [6:0] R2 = 7'b0000010;
    localparam logic [6:0] R3 = 7'b0000001;

    localparam logic [6:0] LEFTWIN  = 7'b1110000;
    localparam logic [6:0] RIGHTWIN = 7'b0000111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DARK,
        ST_GO,
        ST_SHOW,
        ST_WIN
    } state_e;

    // Codes 0..6 are bar positions left to right, so a step is +/-1.
    typedef enum logic [3:0] {
        M_L3   = 4'd0,
        M_L2   = 4'd1,
        M_L1   = 4'd2,
        M_C    = 4'd3,
        M_R1   = 4'd4,
        M_R2   = 4'd5,
        M_R3   = 4'd6,
        M_LWIN = 4'd7,
        M_RWIN = 4'd8
    } mark_e;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_LPULL,
        EV_RPULL,
        EV_LJUMP,
        EV_RJUMP
    } ev_e;

    function automatic logic is_win(mark_e m);
        return (m == M_LWIN) || (m == M_RWIN);
    endfunction

    function automatic logic [6:0] mark_leds(mark_e m);
        logic [6:0] p;
        p = C;
        unique case (m)
            M_L3:    p = L3;
            M_L2:    p = L2;
            M_L1:    p = L1;
            M_C:     p = C;
            M_R1:    p = R1;
            M_R2:    p = R2;
            M_R3:    p = R3;
            M_LWIN:  p = LEFTWIN;
            M_RWIN:  p = RIGHTWIN;
            default: p = C;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/tow_marker.sv
// Next-marker function: step rules, end-of-bar wins and the
// favour-the-loser double steps for pulls.
module tow_marker
    import tow_pkg::*;
(
    input  mark_e mark_i,
    input  ev_e   ev_i,
    output mark_e mark_o
);

    mark_e left_1;
    mark_e right_1;

    assign left_1  = mark_e'(mark_i - 4'd1);
    assign right_1 = mark_e'(mark_i + 4'd1);

    always_comb begin
        mark_o = mark_i;
        if (!is_win(mark_i)) begin
            unique case (ev_i)
                EV_LPULL: begin
                    if (mark_i == M_L3)
                        mark_o = M_LWIN;
                    else if (mark_i == M_R3)
                        mark_o = M_R1;
                    else
                        mark_o = left_1;
                end
                EV_RPULL: begin
                    if (mark_i == M_R3)
                        mark_o = M_RWIN;
                    else if (mark_i == M_L3)
                        mark_o = M_L1;
                    else
                        mark_o = right_1;
                end
                // A false start only ever helps the opponent by one step.
                EV_LJUMP: begin
                    if (mark_i == M_R3)
                        mark_o = M_RWIN;
                    else
                        mark_o = right_1;
                end
                EV_RJUMP: begin
                    if (mark_i == M_L3)
                        mark_o = M_LWIN;
                    else
                        mark_o = left_1;
                end
                default: mark_o = mark_i;
            endcase
        end
    end

endmodule

// File: rtl/tow_top.sv
// Tug-of-war reaction game top. Define TOW_RANDOM_DELAY_EN to
// randomise the dark phase from an LFSR; otherwise it is fixed.
module tow_top
    import tow_pkg::*;
#(
    parameter int         IDLE_CYCLES    = 16,
    parameter int         DARK_MIN       = 8,
    parameter int         DARK_RAND_BITS = 4,
    parameter int         SCORE_CYCLES   = 16,
    parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pbl,
    input  logic       pbr,
    output logic [6:0] leds_out
);

    localparam int CNT_W = 16;

    // [0],[1] synchronise; [2] holds the previous value for edge detect.
    logic [2:0] pbl_q;
    logic [2:0] pbr_q;
    logic       edge_l;
    logic       edge_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pbl_q <= 3'b000;
            pbr_q <= 3'b000;
        end else begin
            pbl_q <= {pbl_q[1:0], pbl};
            pbr_q <= {pbr_q[1:0], pbr};
        end
    end

    assign edge_l = pbl_q[1] & ~pbl_q[2];
    assign edge_r = pbr_q[1] & ~pbr_q[2];

    logic [CNT_W-1:0] dark_len;

`ifdef TOW_RANDOM_DELAY_EN
    logic [7:0] lfsr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lfsr_q <= LFSR_SEED;
        else
            lfsr_q <= {lfsr_q[6:0],
                       lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    assign dark_len = CNT_W'(DARK_MIN)
                    + CNT_W'(lfsr_q[DARK_RAND_BITS-1:0]);
`else
    assign dark_len = CNT_W'(DARK_MIN + 2 ** (DARK_RAND_BITS - 1));
`endif

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    mark_e            marker_q;
    logic [6:0]       leds_q;
    ev_e              ev;
    mark_e            marker_nx;

    always_comb begin
        ev = EV_NONE;
        if (edge_l != edge_r) begin
            if (state_q == ST_DARK)
                ev = edge_l ? EV_LJUMP : EV_RJUMP;
            else if (state_q == ST_GO)
                ev = edge_l ? EV_LPULL : EV_RPULL;
        end
    end

    tow_marker u_marker (
        .mark_i (marker_q),
        .ev_i   (ev),
        .mark_o (marker_nx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            marker_q <= M_C;
            leds_q   <= DARK;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cnt_q == CNT_W'(IDLE_CYCLES)) begin
                        state_q <= ST_DARK;
                        cnt_q   <= dark_len - CNT_W'(1);
                        leds_q  <= DARK;
                    end else begin
                        cnt_q  <= cnt_q + CNT_W'(1);
                        leds_q <= IDLE_PAT;
                    end
                end
                ST_DARK: begin
                    // A press beats timer expiry in the same cycle.
                    if (edge_l || edge_r) begin
                        marker_q <= marker_nx;
                        leds_q   <= mark_leds(marker_nx);
                        cnt_q    <= '0;
                        state_q  <= ST_SHOW;
                    end else if (cnt_q == '0) begin
                        leds_q  <= ALL_ON;
                        state_q <= ST_GO;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_GO: begin
                    if (edge_l || edge_r) begin
                        marker_q <= marker_nx;
                        leds_q   <= mark_leds(marker_nx);
                        cnt_q    <= '0;
                        state_q  <= ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == CNT_W'(SCORE_CYCLES - 1)) begin
                        if (is_win(marker_q)) begin
                            state_q <= ST_WIN;
                        end else begin
                            state_q <= ST_DARK;
                            cnt_q   <= dark_len - CNT_W'(1);
                            leds_q  <= DARK;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_WIN: begin
                    leds_q <= mark_leds(marker_q);
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    leds_q  <= DARK;
                end
            endcase
        end
    end

    assign leds_out = leds_q;

endmodule

// File: tb/tb_tow_top.sv
// Randomised bench for tow_top against a signed-position game model.
module tb_tow_top;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pbl = 1'b0;
    logic       pbr = 1'b0;
    logic [6:0] leds;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: pos in -3..3 (negative = left), win -1 left, +1 right.
    int pos = 0;
    int win = 0;
    int script[$];

    always #5 clk = ~clk;

    tow_top dut (
        .clk      (clk),
        .rst      (rst),
        .pbl      (pbl),
        .pbr      (pbr),
        .leds_out (leds)
    );

    task automatic chk(input string tag, input logic [6:0] got,
                       input logic [6:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] model_leds();
        logic [6:0] c;
        c = 7'b0001000;
        if (win < 0) return 7'b1110000;
        if (win > 0) return 7'b0000111;
        if (pos < 0) return c << (-pos);
        return c >> pos;
    endfunction

    // 0 L pull, 1 R pull, 2 tie in GO, 3 L jump, 4 R jump, 5 tie in dark
    task automatic model_apply(input int act);
        case (act)
            0: if (pos == -3) win = -1;
               else if (pos == 3) pos = 1;
               else pos--;
            1: if (pos == 3) win = 1;
               else if (pos == -3) pos = -1;
               else pos++;
            3: if (pos == 3) win = 1;
               else pos++;
            4: if (pos == -3) win = -1;
               else pos--;
            default: ;
        endcase
    endtask

    task automatic wait_eq(input logic [6:0] exp, input string tag);
        int k;
        k = 0;
        while (leds !== exp && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk(tag, leds, exp);
    endtask

    task automatic wait_ne(input logic [6:0] val);
        int k;
        k = 0;
        while (leds === val && k < 300) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic press(input logic l, input logic r);
        @(negedge clk);
        pbl = l;
        pbr = r;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        pbl = 1'b0;
        pbr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        pbl = 1'b0;
        pbr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_leds", leds, 7'b0000000);
        rst = 1'b0;
        pos = 0;
        win = 0;
        wait_eq(7'b1001101, "idle");
    endtask

    task automatic do_round(input int act);
        wait_eq(7'b0000000, "dark");
        if (act >= 3) begin
            press(act == 3 || act == 5, act == 4 || act == 5);
            wait_ne(7'b0000000);
        end else begin
            wait_eq(7'b1111111, "go");
            press(act == 0 || act == 2, act == 1 || act == 2);
            wait_ne(7'b1111111);
        end
        model_apply(act);
        chk($sformatf("round_act%0d", act), leds, model_leds());
    endtask

    task automatic win_hold();
        repeat (3) begin
            repeat (10) @(negedge clk);
            press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        repeat (20) @(negedge clk);
        chk("win_hold", leds, model_leds());
    endtask

    task automatic run_script();
        foreach (script[i]) begin
            do_round(script[i]);
            if (win != 0) begin
                win_hold();
                break;
            end
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: run did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_init", leds, 7'b0000000);

        do_reset(); script = '{0, 0, 0, 0};             run_script();
        do_reset(); script = '{1, 1, 1, 1};             run_script();
        do_reset(); script = '{3, 3, 3, 3};             run_script();
        do_reset(); script = '{4, 4, 4, 4};             run_script();
        do_reset(); script = '{0, 0, 0, 1, 1, 1, 1, 0, 0}; run_script();
        do_reset(); script = '{1, 1, 1, 0};             run_script();
        do_reset(); script = '{0, 2, 1, 1, 2, 5};       run_script();

        do_reset();
        script = '{0, 0};
        run_script();
        wait_eq(7'b0000000, "dark_mid");
        wait_eq(7'b1111111, "go_mid");
        #1 rst = 1'b1;
        #1 chk("rst_async", leds, 7'b0000000);
        @(negedge clk);
        rst = 1'b0;
        pos = 0;
        win = 0;
        wait_eq(7'b1001101, "idle_mid");
        script = '{0};
        run_script();

        repeat (6) begin
            do_reset();
            script.delete();
            repeat (14) script.push_back(int'($urandom_range(0, 5)));
            run_script();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
